rep_tx_scheduler: RTL
=====================

Name: rep_tx_scheduler

Overview:
Sequencing controller for the uplink repetition stage of the NB-IoT transmitter chain. It buffers 16-bit coded blocks from the upstream encoder and replays each block bit-serially N times (N = configured repetition count). Output uses a valid/ready handshake to the channel interleaver. A per-block completion pulse goes to the chain controller.

Parameters:
DATA_W, 16, bits per coded block
REP_W, 8, width of repetition count (max N = 2^REP_W - 1)
FIFO_DEPTH, 2, input block buffer entries (power of 2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
abort  in  1  synchronous flush; highest priority after reset
cfg_rep  in  REP_W  repetition count N; 0 treated as 1
in_valid  in  1  upstream block valid
in_ready  out  1  block accepted on in_valid & in_ready at clk edge
in_data  in  DATA_W  coded block; in_data[0] is transmitted first
out_valid  out  1  serial bit valid
out_ready  in  1  downstream accepts bit
out_bit  out  1  current serial bit
out_first  out  1  high with bit 0 of every repetition
out_last  out  1  high with final bit of final repetition
block_done  out  1  one-cycle pulse per completed block
busy  out  1  state != IDLE or FIFO non-empty
rep_idx  out  REP_W  current repetition index, 0..N-1

Behaviour:
- Reset (reset=0, async): state=IDLE, FIFO empty, counters 0, shift reg 0. out_valid, out_bit, out_first, out_last, block_done and busy = 0. rep_idx=0. in_ready=0 while reset=0.
- in_ready = (fifo_count < FIFO_DEPTH) & !abort & reset. No bypass: a full FIFO does not accept in the same cycle it pops.
- Simultaneous push and pop: count unchanged, data order preserved.
- FSM states:
  - IDLE -> LOAD when FIFO is non-empty.
  - LOAD (1 cycle): pop FIFO head into shift reg. Latch Nlat = (cfg_rep==0 ? 1 : cfg_rep). Clear bit_cnt and rep_idx. -> SEND.
  - SEND: out_valid=1, out_bit=shreg[bit_cnt], out_first=(bit_cnt==0), out_last=(bit_cnt==DATA_W-1 & rep_idx==Nlat-1).
    - On out_valid & out_ready: bit_cnt++. At DATA_W-1, bit_cnt wraps to 0 and rep_idx++.
    - On the out_last handshake -> DONE.
    - With out_ready=0, all outputs hold stable.
  - DONE (1 cycle): block_done=1, out_valid=0. -> LOAD if FIFO non-empty, else IDLE.
- cfg_rep changes take effect only at the next LOAD.
- Latency: block accepted at edge t into an empty FIFO in IDLE: FIFO non-empty after t, LOAD in cycle t+1, first out_valid in cycle t+2.
- Inter-block gap is 2 cycles (DONE + LOAD) with out_valid=0.
- Per block: exactly DATA_W*Nlat output handshakes and one block_done.
- abort=1 at an edge: FIFO cleared, state=IDLE, counters 0. out_valid, out_first and out_last drop next cycle. block_done is not asserted for the aborted block. An abort in the DONE cycle still suppresses nothing already pulsed.
- Reset asserted mid-block: outputs go to reset values immediately; the block is lost.

Test Plan:
1. in_data=16'hA5C3, cfg_rep=2, out_ready=1 -> 32 bits, sequence 1100001110100101 twice. out_first on bits 1 and 17; out_last on bit 32. block_done one cycle later. First out_valid 2 cycles after the accept edge.
2. in_data=16'hFFFF, cfg_rep=0 -> 16 ones, a single block_done, rep_idx stays 0.
3. 16'hA5C3, cfg_rep=1, out_ready alternating 1/0 -> out_bit/out_first/out_last stable while stalled. Exactly 16 handshakes, same bit sequence.
4. out_ready=0, push blocks 16'h0001, 16'h0002, 16'h0003, 16'h0004 back-to-back -> three accepted, then in_ready=0 and block 4 stalls. Release out_ready with cfg_rep=1 -> block 4 accepted after block 2 is loaded. Output order is 1, 2, 3, 4 with 2-cycle gaps and 4 block_done pulses.
5. abort pulsed at bit 5 of rep 0 with one block queued -> out_valid=0 next cycle, no block_done, busy=0, in_ready=1. A following block 16'h8000 (cfg_rep=1) streams 15 zeros then a 1.
6. reset driven low mid-SEND -> all outputs 0 asynchronously. After release, FIFO is empty and a new block streams normally.

Source files
------------

// File: rtl/rep_tx_scheduler.sv
// Small circular block buffer with synchronous clear; no bypass.
// Latency: a pushed entry is visible at rd_dat one cycle after the push edge.
// Backpressure: the caller must not push when full or pop when empty.
module rep_tx_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wr_dat,
    output logic [W-1:0]  rd_dat,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push && !clr) mem[wr_ptr_q] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_ptr_q];
    assign count  = cnt_q;
endmodule

// Buffers coded blocks and replays each one LSB-first, N times, as a bit stream.
// Latency: accept at edge t -> LOAD in cycle t+1 -> first bit valid in cycle t+2; 2 idle cycles between blocks.
// Backpressure: out_ready low freezes the stream; in_ready drops while the buffer is full or abort is high.
module rep_tx_scheduler #(
    parameter int DATA_W     = 16,
    parameter int REP_W      = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              abort,
    input  logic [REP_W-1:0]  cfg_rep,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              out_first,
    output logic              out_last,
    output logic              block_done,
    output logic              busy,
    output logic [REP_W-1:0]  rep_idx
);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] BIT_MAX = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0]   rep_idx_q, rep_idx_d;
    logic [REP_W-1:0]   nlat_q, nlat_d;
    logic               out_valid_q, out_valid_d;
    logic               out_bit_q, out_bit_d;
    logic               out_first_q, out_first_d;
    logic               out_last_q, out_last_d;
    logic               block_done_q, block_done_d;

    logic [CW-1:0]      fifo_cnt;
    logic [DATA_W-1:0]  fifo_head;
    logic               fifo_push, fifo_pop, fifo_nempty;

    assign fifo_nempty = (fifo_cnt != '0);
    assign in_ready    = (fifo_cnt < CW'(FIFO_DEPTH)) && !abort && reset;
    assign fifo_push   = in_valid && in_ready;
    assign fifo_pop    = (state_q == LOAD) && !abort;

    rep_tx_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .clr    (abort),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .wr_dat (in_data),
        .rd_dat (fifo_head),
        .count  (fifo_cnt)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        rep_idx_d = rep_idx_q;
        nlat_d    = nlat_q;
        case (state_q)
            IDLE: if (fifo_nempty) state_d = LOAD;
            LOAD: begin
                shreg_d   = fifo_head;
                nlat_d    = (cfg_rep == '0) ? REP_W'(1) : cfg_rep;
                bit_cnt_d = '0;
                rep_idx_d = '0;
                state_d   = SEND;
            end
            SEND: if (out_valid_q && out_ready) begin
                // rep_idx holds N-1 through DONE so it never reports N
                if (out_last_q) begin
                    bit_cnt_d = '0;
                    state_d   = DONE;
                end else if (bit_cnt_q == BIT_MAX) begin
                    bit_cnt_d = '0;
                    rep_idx_d = rep_idx_q + REP_W'(1);
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = fifo_nempty ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            rep_idx_d = '0;
        end
        // Outputs are decoded from next state so they leave the flops glitch-free
        out_valid_d  = (state_d == SEND);
        out_bit_d    = out_valid_d && shreg_d[bit_cnt_d];
        out_first_d  = out_valid_d && (bit_cnt_d == '0);
        out_last_d   = out_valid_d && (bit_cnt_d == BIT_MAX) && (rep_idx_d == nlat_d - REP_W'(1));
        block_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            rep_idx_q    <= '0;
            nlat_q       <= REP_W'(1);
            out_valid_q  <= 1'b0;
            out_bit_q    <= 1'b0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
            block_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            rep_idx_q    <= rep_idx_d;
            nlat_q       <= nlat_d;
            out_valid_q  <= out_valid_d;
            out_bit_q    <= out_bit_d;
            out_first_q  <= out_first_d;
            out_last_q   <= out_last_d;
            block_done_q <= block_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_bit    = out_bit_q;
    assign out_first  = out_first_q;
    assign out_last   = out_last_q;
    assign block_done = block_done_q;
    assign rep_idx    = rep_idx_q;
    assign busy       = (state_q != IDLE) || fifo_nempty;
endmodule
